// File: rtl/sgdmac_pkg.sv
// sgdmac_pkg: shared FSM state, AXI constants and command field slices for the SG-DMA write engine
package sgdmac_pkg;
  typedef enum logic [1:0] {IDLE, WREQ, WDATA, WRESP} state_e;
  localparam logic [15:0] BURST_BYTES = 16'd64;
  localparam logic [2:0] AXI_SIZE_4B = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int CMD_ADDR_MSB = 47;
  localparam int CMD_ADDR_LSB = 16;
  localparam int CMD_LEN_MSB = 15;
  localparam logic [15:0] LEN_WORD_MASK = 16'hFFFC;
  function automatic logic [3:0] burst_awlen(input logic [15:0] rem);
    return (rem >= BURST_BYTES) ? 4'hF : rem[5:2] - 4'd1;
  endfunction
endpackage

// File: rtl/sgdmac_wbeat.sv
// sgdmac_wbeat: W-channel beat counter; flags the final beat of the burst whose length was loaded at AW
// Ports: clk, rst (sync active-high), load_i (AW handshake), len_i (awlen to latch),
//        adv_i (W handshake), wlast_o (current beat is the last one)
module sgdmac_wbeat (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] len_i,
  input  logic       adv_i,
  output logic       wlast_o
);
  logic [3:0] beat_q, beat_d, len_q, len_d;
  always_comb begin
    beat_d = load_i ? 4'd0 : adv_i ? beat_q + 4'd1 : beat_q;
    len_d  = load_i ? len_i : len_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= 4'd0;
      len_q  <= 4'd0;
    end else begin
      beat_q <= beat_d;
      len_q  <= len_d;
    end
  end
  assign wlast_o = beat_q == len_q;
endmodule

// File: rtl/sgdmac_write.sv
// sgdmac_write: SG-DMA write engine draining a FWFT FIFO into 64-byte AXI INCR write bursts
// Ports: clk, rst (sync active-high); start_i/cmd_i {dst[31:0], len[15:0]}, done_o, err_o;
//        fifo_cnt_i/fifo_rdata_i/fifo_rden_o (FWFT data FIFO); AXI AW, W and B channels.
// Build option: define SGDMAC_WRITE_ERR_EN to make err_o a sticky non-OKAY write-response flag,
//        otherwise err_o is 0 and bresp_i is ignored.
module sgdmac_write
  import sgdmac_pkg::*;
#(
  parameter int FIFO_DEPTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [47:0]                 cmd_i,
  output logic                        done_o,
  output logic                        err_o,
  input  logic [$clog2(FIFO_DEPTH):0] fifo_cnt_i,
  input  logic [31:0]                 fifo_rdata_i,
  output logic                        fifo_rden_o,
  output logic [3:0]                  awid_o,
  output logic [3:0]                  wid_o,
  output logic [31:0]                 awaddr_o,
  output logic [3:0]                  awlen_o,
  output logic [2:0]                  awsize_o,
  output logic [1:0]                  awburst_o,
  output logic                        awvalid_o,
  input  logic                        awready_i,
  output logic [31:0]                 wdata_o,
  output logic [3:0]                  wstrb_o,
  output logic                        wlast_o,
  output logic                        wvalid_o,
  input  logic                        wready_i,
  input  logic [1:0]                  bresp_i,
  input  logic                        bvalid_i,
  output logic                        bready_o
);
  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d, start_len;
  logic        aw_hold_q, aw_hold_d;
  logic        aw_hs, w_hs, b_hs;
  assign start_len   = cmd_i[CMD_LEN_MSB:0] & LEN_WORD_MASK;
  assign awid_o      = 4'd0;
  assign wid_o       = 4'd0;
  assign awaddr_o    = addr_q;
  assign awlen_o     = burst_awlen(rem_q);
  assign awsize_o    = AXI_SIZE_4B;
  assign awburst_o   = AXI_BURST_INCR;
  assign wstrb_o     = 4'hF;
  assign wdata_o     = fifo_rdata_i;
  assign done_o      = state_q == IDLE;
  // AW waits until the whole burst sits in the FIFO so W never stalls on data; once raised it is held
  assign awvalid_o   = (state_q == WREQ) && (aw_hold_q || int'(fifo_cnt_i) >= int'(awlen_o) + 1);
  assign wvalid_o    = state_q == WDATA;
  assign fifo_rden_o = wvalid_o & wready_i;
  assign bready_o    = state_q == WRESP;
  assign aw_hs       = awvalid_o & awready_i;
  assign w_hs        = fifo_rden_o;
  assign b_hs        = bready_o & bvalid_i;
  sgdmac_wbeat u_wbeat (
    .clk    (clk),
    .rst    (rst),
    .load_i (aw_hs),
    .len_i  (awlen_o),
    .adv_i  (w_hs),
    .wlast_o(wlast_o)
  );
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    aw_hold_d = awvalid_o & ~awready_i;
    case (state_q)
      IDLE: if (start_i) begin
        addr_d  = cmd_i[CMD_ADDR_MSB:CMD_ADDR_LSB];
        rem_d   = start_len;
        state_d = (start_len == 16'd0) ? IDLE : WREQ;
      end
      WREQ: if (aw_hs) begin
        addr_d  = addr_q + 32'(BURST_BYTES);
        rem_d   = (rem_q < BURST_BYTES) ? 16'd0 : rem_q - BURST_BYTES;
        state_d = WDATA;
      end
      WDATA: if (w_hs && wlast_o) state_d = WRESP;
      WRESP: if (b_hs) state_d = (rem_q == 16'd0) ? IDLE : WREQ;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      rem_q     <= 16'd0;
      aw_hold_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      aw_hold_q <= aw_hold_d;
    end
  end
`ifdef SGDMAC_WRITE_ERR_EN
  logic err_q, err_d;
  always_comb begin
    err_d = err_q;
    if (done_o && start_i) err_d = 1'b0;
    else if (b_hs && bresp_i != AXI_RESP_OKAY) err_d = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else err_q <= err_d;
  end
  assign err_o = err_q;
`else
  logic unused_bresp;
  assign unused_bresp = ^bresp_i;
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_sgdmac_write.sv
// tb_sgdmac_write: randomized self-checking bench for sgdmac_write against a burst/FIFO reference model
module tb_sgdmac_write;
  localparam int FIFO_DEPTH = 64;
`ifdef SGDMAC_WRITE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  typedef struct packed {logic [31:0] a; logic [3:0] l;} aw_t;
  logic        clk, rst, start_i, done_o, err_o, fifo_rden_o;
  logic [47:0] cmd_i;
  logic [6:0]  fifo_cnt_i;
  logic [31:0] fifo_rdata_i, awaddr_o, wdata_o;
  logic [3:0]  awid_o, wid_o, awlen_o, wstrb_o;
  logic [2:0]  awsize_o;
  logic [1:0]  awburst_o, bresp_i;
  logic        awvalid_o, awready_i, wlast_o, wvalid_o, wready_i, bvalid_i, bready_o;
  logic [31:0] src_q[$], fifo_q[$], exp_d[$];
  aw_t         exp_aw[$];
  int          tests = 0, fails = 0;

  sgdmac_write #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cmd_i(cmd_i), .done_o(done_o), .err_o(err_o),
    .fifo_cnt_i(fifo_cnt_i), .fifo_rdata_i(fifo_rdata_i), .fifo_rden_o(fifo_rden_o),
    .awid_o(awid_o), .wid_o(wid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i), .wdata_o(wdata_o),
    .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_cnt_i   = 7'(fifo_q.size());
    fifo_rdata_i = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic do_xfer(input logic [31:0] a, input logic [15:0] l, input bit bad);
    int words, rem, wl, pops;
    bit fin, held, bp, err_exp, aw_ph, w_ph, b_ph;
    logic [31:0] ad, w;
    aw_t e;
    words = int'(l[15:2]);
    src_q.delete(); fifo_q.delete(); exp_d.delete(); exp_aw.delete();
    for (int i = 0; i < words; i++) begin
      w = $urandom;
      src_q.push_back(w);
      exp_d.push_back(w);
    end
    rem = words * 4;
    ad = a;
    while (rem > 0) begin
      e.a = ad;
      e.l = 4'(((rem >= 64) ? 16 : rem / 4) - 1);
      exp_aw.push_back(e);
      ad = ad + 32'd64;
      rem = rem - ((rem >= 64) ? 64 : rem);
    end
    @(negedge clk);
    start_i = 1'b1; cmd_i = {a, l}; drive_fifo();
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    check("start_err", err_o, 0);
    check("start_done", done_o, words == 0);
    fin = words == 0; held = 0; bp = 0; wl = 0; err_exp = 0; pops = 0;
    for (int cyc = 0; !fin && cyc < 4000; cyc++) begin
      if (src_q.size() > 0 && fifo_q.size() < FIFO_DEPTH && $urandom_range(3) != 0)
        fifo_q.push_back(src_q.pop_front());
      drive_fifo();
      awready_i = $urandom_range(1) == 1;
      wready_i  = $urandom_range(1) == 1;
      bvalid_i  = bp && ($urandom_range(1) == 1);
      bresp_i   = bad ? 2'b10 : 2'b00;
      #1;
      aw_ph = wl == 0 && !bp && exp_aw.size() > 0;
      w_ph  = wl > 0;
      b_ph  = bp;
      check("done_busy", done_o, 0);
      check("wvalid", wvalid_o, w_ph);
      check("rden", fifo_rden_o, wvalid_o && wready_i);
      check("bready", bready_o, b_ph);
      if (aw_ph) check("awvalid", awvalid_o, held || fifo_q.size() >= int'(exp_aw[0].l) + 1);
      else check("awvalid_idle", awvalid_o, 0);
      held = awvalid_o && !awready_i;
      if (w_ph && wvalid_o && wready_i) begin
        check("wdata", wdata_o, exp_d.pop_front());
        check("wlast", wlast_o, wl == 1);
        void'(fifo_q.pop_front());
        pops++;
        wl--;
        if (wl == 0) bp = 1;
      end
      if (b_ph && bvalid_i && bready_o) begin
        bp = 0;
        if (bresp_i != 2'b00) err_exp = ERR_EN;
        if (exp_aw.size() == 0) fin = 1;
      end
      if (aw_ph && awvalid_o && awready_i) begin
        e = exp_aw.pop_front();
        check("awaddr", awaddr_o, e.a);
        check("awlen", awlen_o, e.l);
        check("awconst", {awid_o, wid_o, awsize_o, awburst_o, wstrb_o}, {4'h0, 4'h0, 3'b010, 2'b01, 4'hF});
        wl = int'(e.l) + 1;
      end
      @(negedge clk);
    end
    if (!fin) check("timeout", 0, 1);
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
    #1;
    check("done", done_o, 1);
    check("pops", pops, words);
    check("err", err_o, err_exp);
    check("awvalid_end", awvalid_o, 0);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; cmd_i = '0; fifo_cnt_i = '0; fifo_rdata_i = '0;
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00;
    @(negedge clk);
    #1;
    check("rst_done", done_o, 1);
    check("rst_valids", {awvalid_o, wvalid_o, bready_o, fifo_rden_o, err_o}, 5'b0);
    rst = 1'b0;
    do_xfer(32'h1000, 16'h0040, 1'b0);
    do_xfer(32'h1000, 16'h0048, 1'b0);
    do_xfer(32'h3000, 16'h0003, 1'b0);
    do_xfer(32'hFFFF_FFC0, 16'h0080, 1'b0);
    // AW gating on FIFO occupancy, then reset in the middle of the data phase
    @(negedge clk);
    fifo_cnt_i = 7'd15; fifo_rdata_i = 32'hA5A5_0000;
    start_i = 1'b1; cmd_i = {32'h2000, 16'h0040};
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check("aw_gate15", awvalid_o, 0);
      @(negedge clk);
    end
    fifo_cnt_i = 7'd16;
    #1 check("aw_gate16", awvalid_o, 1);
    awready_i = 1'b1;
    @(negedge clk);
    awready_i = 1'b0; wready_i = 1'b1;
    #1 check("wdata_phase", wvalid_o, 1);
    @(negedge clk);
    wready_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_done", done_o, 1);
    check("rst_mid_wvalid", wvalid_o, 0);
    check("rst_mid_rden", fifo_rden_o, 0);
    rst = 1'b0;
    do_xfer(32'h0100, 16'h0020, 1'b1);
    repeat (3) @(negedge clk);
    #1 check("err_sticky", err_o, ERR_EN);
    do_xfer(32'h0200, 16'h0044, 1'b0);
    for (int n = 0; n < 10; n++)
      do_xfer($urandom, 16'($urandom_range(400)), $urandom_range(3) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
